// File: rtl/sram_confreg_responder.sv
// rtl/sram_confreg_responder.sv - data-SRAM responder implementing the confreg register page
// Optional feature macro: CONFREG_PRESCALE_EN (timer advances once every PRESCALE clocks)
// Ports:
//   clk        system clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   en         access strobe (data_sram_en)
//   wen        byte write enables; zero with en=1 means read
//   addr       physical byte address
//   wdata      write data
//   rdata      registered read data, one-edge latency
//   switch     board switch levels, already synchronised
//   led        LED register
//   timer_int  level interrupt, high while the compare match is pending
module sram_confreg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1FAF_0000,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_int
);

  localparam logic [15:0] OFF_SCRATCH = 16'h0000;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_STATUS  = 16'hE008;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF020;

  if (PRESCALE < 2 || PRESCALE > 256) begin : gBadPrescale
    $error("sram_confreg_responder: PRESCALE must be in 2..256");
  end

  logic [31:0] scratchReg;
  logic [31:0] timerReg;
  logic [31:0] compareReg;
  logic [15:0] ledReg;
  logic        pendingReg;

  logic        pageHit;
  logic [13:0] wordOff;
  logic        selScratch, selTimer, selCompare, selStatus, selLed, selSwitch;
  logic        doRead, doWrite;
  logic        scratchWr, timerWr, compareWr, ledWr, statusClr;
  logic        timerTick, timerMatch;
  logic [31:0] readValue;
  logic [31:0] ledMerged;
  logic        unusedAddrBits;

  // Byte-lane merge shared by every RW register.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
    end
    return merged;
  endfunction

  // Registers are word-sized, so the byte offset within the word plays no part in decode.
  assign unusedAddrBits = &{1'b0, addr[1:0]};
  assign pageHit = (addr[31:16] == BASE_ADDR[31:16]);
  assign wordOff = addr[15:2];

  assign selScratch = pageHit && (wordOff == OFF_SCRATCH[15:2]);
  assign selTimer   = pageHit && (wordOff == OFF_TIMER[15:2]);
  assign selCompare = pageHit && (wordOff == OFF_COMPARE[15:2]);
  assign selStatus  = pageHit && (wordOff == OFF_STATUS[15:2]);
  assign selLed     = pageHit && (wordOff == OFF_LED[15:2]);
  assign selSwitch  = pageHit && (wordOff == OFF_SWITCH[15:2]);

  assign doRead  = en && (wen == 4'b0000);
  assign doWrite = en && (wen != 4'b0000);

  assign scratchWr = doWrite && selScratch;
  assign timerWr   = doWrite && selTimer;
  assign compareWr = doWrite && selCompare;
  assign ledWr     = doWrite && selLed;
  assign statusClr = doWrite && selStatus && wen[0] && wdata[0];

  assign ledMerged = mergeBytes({16'h0000, ledReg}, wdata, wen);

  // A COMPARE write in the same cycle suppresses the match so software can re-arm cleanly.
  assign timerMatch = (timerReg == compareReg) && !compareWr;

`ifdef CONFREG_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaleCnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescaleCnt <= '0;
    end else if (timerWr || prescaleCnt == PS_LAST) begin
      prescaleCnt <= '0;
    end else begin
      prescaleCnt <= prescaleCnt + 1'b1;
    end
  end

  // Tick on the cycle the counter wraps back to zero.
  assign timerTick = (prescaleCnt == PS_LAST);
`else
  assign timerTick = 1'b1;
`endif

  always_comb begin
    readValue = 32'h0000_0000;
    if (selScratch) readValue = scratchReg;
    if (selTimer)   readValue = timerReg;
    if (selCompare) readValue = compareReg;
    if (selStatus)  readValue = {31'h0, pendingReg};
    if (selLed)     readValue = {16'h0000, ledReg};
    if (selSwitch)  readValue = {24'h00_0000, switch};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata      <= 32'h0000_0000;
      scratchReg <= 32'h0000_0000;
      timerReg   <= 32'h0000_0000;
      compareReg <= 32'hFFFF_FFFF;
      ledReg     <= 16'h0000;
      pendingReg <= 1'b0;
    end else begin
      if (doRead) begin
        rdata <= readValue;
      end
      if (scratchWr) begin
        scratchReg <= mergeBytes(scratchReg, wdata, wen);
      end
      if (ledWr) begin
        ledReg <= ledMerged[15:0];
      end
      // A CPU write wins over the increment; unwritten bytes keep the pre-edge count.
      if (timerWr) begin
        timerReg <= mergeBytes(timerReg, wdata, wen);
      end else if (timerTick) begin
        timerReg <= timerReg + 32'd1;
      end
      if (compareWr) begin
        compareReg <= mergeBytes(compareReg, wdata, wen);
      end
      // Set beats clear so a match on the clearing edge is never lost.
      if (timerMatch) begin
        pendingReg <= 1'b1;
      end else if (compareWr || statusClr) begin
        pendingReg <= 1'b0;
      end
    end
  end

  assign led       = ledReg;
  assign timer_int = pendingReg;

endmodule

// File: doc/sram_confreg_responder.md
Name: sram_confreg_responder

Overview:
- Responder (slave) end of the CPU's data-SRAM interface.
- Implements a memory-mapped configuration/peripheral register page: scratch register, LED output, switch input, free-running timer with compare, and interrupt status.
- Sits between the CPU top's data_sram_* ports and board I/O; timer_int feeds one bit of the CPU's int[15:0] input.
- The CPU presents physical addresses (kseg1 0xBFAF_xxxx arrives as 0x1FAF_xxxx).

Parameters:
- BASE_ADDR, 32'h1FAF_0000, page base; the block is selected when addr[31:16] == BASE_ADDR[31:16].
- PRESCALE, 4, timer tick divisor; used only with CONFREG_PRESCALE_EN, legal range 2..256.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- en  in  1  access strobe (data_sram_en)
- wen  in  4  byte write enables; wen==0 with en=1 is a read
- addr  in  32  physical byte address
- wdata  in  32  write data
- rdata  out  32  read data, registered
- switch  in  8  board switch levels, already synchronised externally
- led  out  16  LED register
- timer_int  out  1  level interrupt, high active

Behaviour:
- Reset is asynchronous and active-low on resetn; single clock clk.
- Reset values: rdata=0, led=0, scratch=0, timer=0, compare=32'hFFFF_FFFF, pending=0, timer_int=0.
- Register map (offset = addr[15:0]; addr[1:0] ignored):
  - 0x0000 SCRATCH: RW, 32 bits.
  - 0xE000 TIMER: RW, 32 bits.
  - 0xE004 COMPARE: RW, 32 bits.
  - 0xE008 STATUS: bit0 = pending; write-1-to-clear via byte0; reads 0 in bits 31:1.
  - 0xF000 LED: RW, bits 15:0; reads 0 in bits 31:16.
  - 0xF020 SWITCH: RO, bits 7:0 zero-extended; writes ignored.
- Unmapped offsets or page miss:
  - Reads return 0.
  - Writes are ignored.
  - No error signal.
- Reads:
  - On a rising edge with en=1 and wen=0, rdata loads the selected value as it was before that edge.
  - Read latency is 1 edge.
  - rdata holds its value in every other cycle, including during writes.
- Writes: on a rising edge with en=1, each byte i with wen[i]=1 is written; partial writes are legal on all RW registers.
- Timer:
  - Increments by 1 each tick; wraps from 32'hFFFF_FFFF to 0.
  - A tick is every clk without the macro.
  - A CPU write to TIMER takes priority over the increment in the same cycle (written bytes take the written value, unwritten bytes keep the old value, no increment that cycle).
- Compare/pending:
  - At each rising edge, if the current timer equals compare and no COMPARE write occurs in that cycle, pending is set.
  - A COMPARE write clears pending.
  - STATUS W1C with wdata[0]=1 and wen[0]=1 clears pending.
  - If set and clear coincide, set wins.
- timer_int equals the pending register, so it is visible 1 edge after the match edge.
- Reset mid-operation: all registers return to reset values immediately; an in-flight read is lost and rdata is 0.

Optional Feature:
- Macro CONFREG_PRESCALE_EN.
- Defined: a prescale counter 0..PRESCALE-1 runs each clk. The timer increments only on the cycle the counter wraps to 0. A TIMER write also resets the prescale counter to 0. The compare check is performed every clk.
- Undefined: no prescale counter; the timer increments every clk; PRESCALE is unused.

Test Plan:
- Reset then read each register -> SCRATCH=0, LED=0, COMPARE=FFFF_FFFF, STATUS=0, timer_int=0; SWITCH reads switch value (switch=8'hA5 -> 0x0000_00A5).
- Write 0x1FAF_0000 with wen=4'b0101, wdata=0x1122_3344 after a full write of 0xAABB_CCDD -> next read = 0xAA22_CC44; write to 0x1FAE_0000 -> no register changes, read returns 0.
- Write TIMER=0xFFFF_FFFE, then read 2 cycles later -> wrap observed: reads 0x0000_0000 (macro off); write in the same cycle as increment leaves exactly the written value.
- COMPARE=0x20, TIMER=0x10 (macro off) -> timer_int rises 1 edge after the timer holds 0x20 and stays high; STATUS write 0x1 -> timer_int low next cycle.
- Pending clear coinciding with a new match edge -> pending stays 1; a COMPARE write clears it even when timer==new compare on that edge.
- With CONFREG_PRESCALE_EN, PRESCALE=4: TIMER=0, wait 12 clks -> TIMER reads 3; resetn pulsed low mid-count -> all outputs 0 and compare FFFF_FFFF asynchronously.
